// File: rtl/aim_sequencer.sv
// Aim sequencer: picks a manual or auto-tracked aim point each frame and hands it to the motor link.
// Optional build macro AIM_SEQ_DROP_CNT_EN adds the drop_cnt output (frames ignored while busy).
module aim_sequencer #(
  parameter int LOCK_ZONE       = 30,
  parameter int LOCK_FRAMES     = 3,
  parameter int COOLDOWN_FRAMES = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_done,
  input  logic [15:0][9:0] aim_x_all,
  input  logic [15:0][9:0] aim_y_all,
  input  logic [15:0]      aim_detected_all,
  input  logic [7:0]       keyboard_data,
  input  logic             cmd_ready,
  output logic             cmd_valid,
  output logic [9:0]       x_coor,
  output logic [9:0]       y_coor,
  output logic             shoot,
  output logic             mode_auto,
  output logic             locked,
  output logic [3:0]       target_idx
`ifdef AIM_SEQ_DROP_CNT_EN
  ,
  output logic [7:0]       drop_cnt
`endif
);

  localparam int LCW = (LOCK_FRAMES > 0) ? $clog2(LOCK_FRAMES + 1) : 1;
  localparam int CDW = (COOLDOWN_FRAMES > 1) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
  localparam logic [LCW-1:0] LF      = LCW'(LOCK_FRAMES);
  localparam logic [CDW-1:0] CD_LAST = CDW'(COOLDOWN_FRAMES - 1);
  localparam logic [10:0]    LZ      = 11'(LOCK_ZONE);
  localparam logic [9:0]     CX      = 10'd320;
  localparam logic [9:0]     CY      = 10'd240;

  typedef enum logic [1:0] {IDLE, SCAN, ISSUE, COOLDOWN} state_t;

  state_t           state_q, state_d;
  logic             mode_auto_q, mode_auto_d;
  logic [1:0]       kb_prev_q, kb_prev_d;
  logic [9:0]       x_q, x_d, y_q, y_d;
  logic             shoot_q, shoot_d;
  logic             locked_q, locked_d;
  logic [3:0]       tidx_q, tidx_d;
  logic [LCW-1:0]   lock_cnt_q, lock_cnt_d;
  logic [CDW-1:0]   cd_cnt_q, cd_cnt_d;
  logic [3:0]       scan_idx_q, scan_idx_d;
  logic             best_found_q, best_found_d;
  logic [3:0]       best_idx_q, best_idx_d;
  logic [10:0]      best_dist_q, best_dist_d;

  logic             key_w, key_a, key_s, key_d, key_l, f1_rise, f2_rise;
  logic [9:0]       cur_dx, cur_dy, sel_dx, sel_dy;
  logic [10:0]      cur_dist;
  logic             cand_better, sel_found, sel_lock;
  logic [3:0]       sel_idx;
  logic [LCW-1:0]   lock_cnt_inc;
  logic             unused_kb;

  function automatic logic [9:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  assign key_w     = keyboard_data[0];
  assign key_a     = keyboard_data[1];
  assign key_s     = keyboard_data[2];
  assign key_d     = keyboard_data[3];
  assign key_l     = keyboard_data[4];
  assign f1_rise   = keyboard_data[5] & ~kb_prev_q[0];
  assign f2_rise   = keyboard_data[6] & ~kb_prev_q[1];
  assign unused_kb = keyboard_data[7];

  // Candidate under examination this SCAN cycle, folded into the running best.
  assign cur_dx      = abs_diff(aim_x_all[scan_idx_q], CX);
  assign cur_dy      = abs_diff(aim_y_all[scan_idx_q], CY);
  assign cur_dist    = {1'b0, cur_dx} + {1'b0, cur_dy};
  assign cand_better = aim_detected_all[scan_idx_q] & (~best_found_q | (cur_dist < best_dist_q));
  assign sel_found   = best_found_q | cand_better;
  assign sel_idx     = cand_better ? scan_idx_q : best_idx_q;
  assign sel_dx      = abs_diff(aim_x_all[sel_idx], CX);
  assign sel_dy      = abs_diff(aim_y_all[sel_idx], CY);
  assign sel_lock    = sel_found & ({1'b0, sel_dx} < LZ) & ({1'b0, sel_dy} < LZ);
  assign lock_cnt_inc = (lock_cnt_q >= LF) ? LF : lock_cnt_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    mode_auto_d  = mode_auto_q;
    kb_prev_d    = keyboard_data[6:5];
    x_d          = x_q;
    y_d          = y_q;
    shoot_d      = shoot_q;
    locked_d     = locked_q;
    tidx_d       = tidx_q;
    lock_cnt_d   = lock_cnt_q;
    cd_cnt_d     = cd_cnt_q;
    scan_idx_d   = scan_idx_q;
    best_found_d = best_found_q;
    best_idx_d   = best_idx_q;
    best_dist_d  = best_dist_q;

    // F1 (manual) has priority over F2 when both rise together.
    if (f1_rise)      mode_auto_d = 1'b0;
    else if (f2_rise) mode_auto_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (frame_done) begin
          if (!mode_auto_q) begin
            x_d        = key_a ? 10'd270 : (key_d ? 10'd370 : CX);
            y_d        = key_w ? 10'd190 : (key_s ? 10'd290 : CY);
            shoot_d    = key_l;
            locked_d   = 1'b0;
            lock_cnt_d = '0;
            state_d    = ISSUE;
          end else begin
            scan_idx_d   = 4'd0;
            best_found_d = 1'b0;
            best_idx_d   = 4'd0;
            best_dist_d  = 11'd0;
            state_d      = SCAN;
          end
        end
      end
      SCAN: begin
        if (cand_better) begin
          best_found_d = 1'b1;
          best_idx_d   = scan_idx_q;
          best_dist_d  = cur_dist;
        end
        scan_idx_d = scan_idx_q + 4'd1;
        if (scan_idx_q == 4'd15) begin
          x_d        = sel_found ? aim_x_all[sel_idx] : CX;
          y_d        = sel_found ? aim_y_all[sel_idx] : CY;
          tidx_d     = sel_found ? sel_idx : 4'd0;
          locked_d   = sel_lock;
          lock_cnt_d = sel_lock ? lock_cnt_inc : '0;
          shoot_d    = sel_lock & (lock_cnt_inc == LF) & key_l;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (cmd_ready) begin
          cd_cnt_d = '0;
          state_d  = shoot_q ? COOLDOWN : IDLE;
        end
      end
      COOLDOWN: begin
        if (frame_done) begin
          if (cd_cnt_q == CD_LAST) begin
            cd_cnt_d   = '0;
            lock_cnt_d = '0;
            state_d    = IDLE;
          end else begin
            cd_cnt_d = cd_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      mode_auto_q  <= 1'b0;
      kb_prev_q    <= 2'b00;
      x_q          <= CX;
      y_q          <= CY;
      shoot_q      <= 1'b0;
      locked_q     <= 1'b0;
      tidx_q       <= 4'd0;
      lock_cnt_q   <= '0;
      cd_cnt_q     <= '0;
      scan_idx_q   <= 4'd0;
      best_found_q <= 1'b0;
      best_idx_q   <= 4'd0;
      best_dist_q  <= 11'd0;
    end else begin
      state_q      <= state_d;
      mode_auto_q  <= mode_auto_d;
      kb_prev_q    <= kb_prev_d;
      x_q          <= x_d;
      y_q          <= y_d;
      shoot_q      <= shoot_d;
      locked_q     <= locked_d;
      tidx_q       <= tidx_d;
      lock_cnt_q   <= lock_cnt_d;
      cd_cnt_q     <= cd_cnt_d;
      scan_idx_q   <= scan_idx_d;
      best_found_q <= best_found_d;
      best_idx_q   <= best_idx_d;
      best_dist_q  <= best_dist_d;
    end
  end

`ifdef AIM_SEQ_DROP_CNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (frame_done && (state_q != IDLE) && (drop_cnt_q != 8'hFF))
      drop_cnt_d = drop_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) drop_cnt_q <= 8'd0;
    else       drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`endif

  assign cmd_valid  = (state_q == ISSUE);
  assign shoot      = cmd_valid & shoot_q;
  assign x_coor     = x_q;
  assign y_coor     = y_q;
  assign mode_auto  = mode_auto_q;
  assign locked     = locked_q;
  assign target_idx = tidx_q;

endmodule

// File: doc/aim_sequencer.md
AIM_SEQUENCER -- requirements
Module: aim_sequencer

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
- LOCK_ZONE, 30, lock window half-width in pixels (strict less-than).
- LOCK_FRAMES, 3, consecutive locked frames required before an auto shot.
- COOLDOWN_FRAMES, 8, frames suppressed after a shot.
REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
- clk  in  1  system clock; one clock; reset is asynchronous and active-high.
- reset  in  1  asynchronous active-high reset.
- frame_done  in  1  one-cycle pulse; target table stable this cycle and for the 16 cycles after it.
- aim_x_all  in  16x10  target centre x.
- aim_y_all  in  16x10  target centre y.
- aim_detected_all  in  16  per-target valid.
- keyboard_data  in  8  level bits: W0 A1 S2 D3 L4 F1=5 F2=6.
- cmd_ready  in  1  motor link accepts command.
- cmd_valid  out  1  command pending.
- x_coor  out  10  commanded x.
- y_coor  out  10  commanded y.
- shoot  out  1  fire flag attached to the command.
- mode_auto  out  1  1 = auto-track mode, 0 = manual mode.
- locked  out  1  selected target is inside the lock window.
- target_idx  out  4  index of the selected target.

Function
REQ-003 Mode SHALL be a register: rising edge of F1 sets manual, rising edge of F2 sets auto; if both rise in the same cycle, manual SHALL win; a change SHALL take effect at the next command load only.
REQ-004 The FSM states SHALL be IDLE, SCAN, ISSUE, COOLDOWN; IDLE SHALL advance only on frame_done.
REQ-005 IDLE with frame_done in manual mode SHALL load the command and go to ISSUE next cycle.
REQ-006 Manual load SHALL set y=190 if W, else 290 if S, else 240; x=270 if A, else 370 if D, else 320; shoot=L. W SHALL beat S and A SHALL beat D.
REQ-007 IDLE with frame_done in auto mode SHALL enter SCAN; SCAN SHALL examine indices 0..15, one per cycle (16 cycles), then load and go to ISSUE.
REQ-008 SCAN SHALL select the detected target with minimum 11-bit |x-320|+|y-240|; replacement only on strictly smaller distance, so the lowest index wins ties.
REQ-009 With no detected target, auto load SHALL give x=320, y=240, shoot=0, locked=0, target_idx=0, and clear lock_cnt.
REQ-010 locked SHALL be 1 iff the selected |dx|<LOCK_ZONE and |dy|<LOCK_ZONE; lock_cnt SHALL increment, saturating at LOCK_FRAMES, on each locked auto load, and clear on an unlocked load or any manual load.
REQ-011 Auto shoot SHALL be 1 iff lock_cnt==LOCK_FRAMES after the update and L is held at load.
REQ-012 ISSUE SHALL hold cmd_valid=1 with x_coor, y_coor and shoot stable until a cycle with cmd_ready=1; the next state SHALL be COOLDOWN if shoot=1, else IDLE; cmd_valid SHALL drop the cycle after acceptance.
REQ-013 frame_done arriving in SCAN, ISSUE or COOLDOWN SHALL be dropped, with no queueing.
REQ-014 COOLDOWN SHALL count COOLDOWN_FRAMES frame_done pulses, then return to IDLE, clearing lock_cnt; no commands are issued in COOLDOWN.
REQ-015 x_coor and y_coor SHALL retain the last loaded value outside ISSUE; shoot SHALL be 0 outside ISSUE.

Reset
REQ-016 Reset SHALL force IDLE, manual mode, cmd_valid=0, shoot=0, locked=0, target_idx=0, x_coor=320, y_coor=240, and clear lock_cnt, cooldown and edge-detect registers (edge history = 0).
REQ-017 Reset asserted mid-SCAN or mid-ISSUE SHALL abandon the command immediately, with no cmd_valid after release until a new frame_done.

Configuration
REQ-018 With macro AIM_SEQ_DROP_CNT_EN defined, an extra output drop_cnt (8 bits) SHALL count frames dropped per REQ-013, saturate at 255, and reset to 0. Without the macro the port and the counter SHALL be absent and behaviour SHALL be otherwise identical.

Verification
REQ-019 Manual mode, W+A held, frame_done, cmd_ready=1 -> one command x=270, y=190, shoot=0, cmd_valid for exactly 1 cycle.
REQ-020 Auto mode, targets idx3 (330,245) and idx7 (325,250), equal distance 15 -> target_idx=3, x=330, y=245, locked=1, command issued 17 cycles after frame_done.
REQ-021 Auto mode, idx2 (322,241) every frame, L held -> shoot=0 on frames 1-2, shoot=1 on frame 3, then 8 frames with no cmd_valid.
REQ-022 Command pending with cmd_ready=0 for 40 cycles, frame_done pulsed during that time -> x, y, shoot stable throughout; the frame is dropped; drop_cnt=1 when the macro is defined.
REQ-023 F1 and F2 rise together -> mode_auto=0; reset mid-SCAN -> x=320, y=240, cmd_valid=0.
REQ-024 Auto mode, no detected target -> command (320,240), locked=0, shoot=0 even with L held.
